operand_fetch_stage: RTL and testbench



---
 rtl/of_pkg.sv | 23 ++
 rtl/of_fwd_mux.sv | 50 +++++
 rtl/operand_fetch_stage.sv | 153 +++++++++++++++
 tb/tb_operand_fetch_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/of_pkg.sv
// Shared types and constants for the operand fetch (ID/EX) stage.
package of_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned NREG_DEFAULT = 32;
    localparam int unsigned REG_AW       = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_WB,
        FWD_MEM,
        FWD_EX
    } fwd_sel_e;

    typedef struct packed {
        logic              reg_write;
        logic              is_load;
        logic [REG_AW-1:0] rd;
    } of_ctrl_t;

endpackage

// File: rtl/of_fwd_mux.sv
// Bypass selector for one source operand: EX, then MEM, then WB, else register file.
module of_fwd_mux
    import of_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned AW   = REG_AW
) (
    input  logic [AW-1:0]   rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic            ex_we,
    input  logic            ex_is_load,
    input  logic [AW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            mem_we,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] value_c
);

    fwd_sel_e sel;

    // A load in EX has no data yet; the load-use stall covers that case.
    always_comb begin
        sel = FWD_RF;
        if (ex_we && !ex_is_load && (ex_rd == rs)) begin
            sel = FWD_EX;
        end else if (mem_we && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb_we && (wb_rd == rs)) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        value_c = rf_data;
        case (sel)
            FWD_EX:  value_c = ex_data;
            FWD_MEM: value_c = mem_data;
            FWD_WB:  value_c = wb_data;
            default: value_c = rf_data;
        endcase
        if (rs == AW'(REG_ZERO)) begin
            value_c = '0;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// RV32I decode-to-execute stage: operand bypassing, load-use stall, ID/EX register.
// Optional macro OF_PERF_CNT_EN adds load-use stall and flush event counters.
module operand_fetch_stage
    import of_pkg::*;
#(
    parameter  int unsigned XLEN = XLEN_DEFAULT,
    parameter  int unsigned NREG = NREG_DEFAULT,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic            id_reg_write,
    input  logic            id_is_load,
    output logic [AW-1:0]   rf_rs1,
    output logic [AW-1:0]   rf_rs2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    input  logic            ex_fwd_we,
    input  logic            ex_fwd_is_load,
    input  logic [AW-1:0]   ex_fwd_rd,
    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic            mem_fwd_we,
    input  logic [AW-1:0]   mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_op_a,
    output logic [XLEN-1:0] ex_op_b,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [AW-1:0]   ex_rd,
    output logic            ex_reg_write,
    output logic            ex_is_load
`ifdef OF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_lu_stalls,
    output logic [31:0]     perf_flushes
`endif
);

    logic [XLEN-1:0] rs1_val_c;
    logic [XLEN-1:0] rs2_val_c;
    logic            lu_stall_c;
    logic            accept_c;
    of_ctrl_t        ctrl_q;

    assign rf_rs1 = id_rs1;
    assign rf_rs2 = id_rs2;

    of_fwd_mux #(.XLEN(XLEN), .AW(AW)) u_fwd_rs1 (
        .rs         (id_rs1),
        .rf_data    (rf_rd1),
        .ex_we      (ex_fwd_we),
        .ex_is_load (ex_fwd_is_load),
        .ex_rd      (ex_fwd_rd),
        .ex_data    (ex_fwd_data),
        .mem_we     (mem_fwd_we),
        .mem_rd     (mem_fwd_rd),
        .mem_data   (mem_fwd_data),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .value_c    (rs1_val_c)
    );

    of_fwd_mux #(.XLEN(XLEN), .AW(AW)) u_fwd_rs2 (
        .rs         (id_rs2),
        .rf_data    (rf_rd2),
        .ex_we      (ex_fwd_we),
        .ex_is_load (ex_fwd_is_load),
        .ex_rd      (ex_fwd_rd),
        .ex_data    (ex_fwd_data),
        .mem_we     (mem_fwd_we),
        .mem_rd     (mem_fwd_rd),
        .mem_data   (mem_fwd_data),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .value_c    (rs2_val_c)
    );

    // Load result is not available until MEM, so a dependent instruction waits one cycle.
    assign lu_stall_c = id_valid && ex_fwd_we && ex_fwd_is_load &&
                        (ex_fwd_rd != AW'(REG_ZERO)) &&
                        ((id_use_rs1 && (ex_fwd_rd == id_rs1)) ||
                         (id_use_rs2 && (ex_fwd_rd == id_rs2)));

    assign id_ready = !lu_stall_c && (!ex_valid || ex_ready);
    assign accept_c = id_valid && id_ready;

    assign ex_rd        = ctrl_q.rd;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_is_load   = ctrl_q.is_load;

    // ID/EX register; a held entry keeps its captured operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_op_a     <= '0;
            ex_op_b     <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ctrl_q      <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept_c) begin
            ex_valid         <= 1'b1;
            ex_pc            <= id_pc;
            ex_op_a          <= rs1_val_c;
            ex_op_b          <= id_use_imm ? id_imm : rs2_val_c;
            ex_rs2_data      <= rs2_val_c;
            ex_imm           <= id_imm;
            ctrl_q.reg_write <= id_reg_write;
            ctrl_q.is_load   <= id_is_load;
            ctrl_q.rd        <= REG_AW'(id_rd);
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

`ifdef OF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_stalls <= '0;
            perf_flushes   <= '0;
        end else begin
            if (lu_stall_c) begin
                perf_lu_stalls <= perf_lu_stalls + 32'd1;
            end
            if (flush) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed scenarios then randomized traffic.
// Honours OF_PERF_CNT_EN when the design is built with it.
module tb_operand_fetch_stage;
    import of_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, id_valid, id_ready;
    logic [31:0] id_pc, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_use_imm, id_reg_write, id_is_load;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        ex_fwd_we, ex_fwd_is_load;
    logic [4:0]  ex_fwd_rd, mem_fwd_rd, wb_rd;
    logic [31:0] ex_fwd_data, mem_fwd_data, wb_data;
    logic        mem_fwd_we, wb_we;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_pc, ex_op_a, ex_op_b, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_is_load;
`ifdef OF_PERF_CNT_EN
    logic [31:0] perf_lu_stalls, perf_flushes;
    logic [31:0] m_lu_cnt, m_fl_cnt;
`endif

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .ex_fwd_we(ex_fwd_we), .ex_fwd_is_load(ex_fwd_is_load),
        .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load)
`ifdef OF_PERF_CNT_EN
        , .perf_lu_stalls(perf_lu_stalls), .perf_flushes(perf_flushes)
`endif
    );

    typedef struct {
        logic [31:0] pc, op_a, op_b, rs2_data, imm;
        logic [4:0]  rd;
        logic        reg_write, is_load;
    } txn_t;

    txn_t m_slot;
    logic m_valid;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference operand: the youngest in-flight producer of rs wins; x0 is always zero.
    function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] rf);
        logic        hit [3];
        logic [31:0] val [3];
        hit[0] = ex_fwd_we && !ex_fwd_is_load && (ex_fwd_rd == rs);  val[0] = ex_fwd_data;
        hit[1] = mem_fwd_we && (mem_fwd_rd == rs);                   val[1] = mem_fwd_data;
        hit[2] = wb_we && (wb_rd == rs);                             val[2] = wb_data;
        if (rs == 5'd0) return 32'd0;
        for (int i = 0; i < 3; i++) if (hit[i]) return val[i];
        return rf;
    endfunction

    function automatic logic ref_load_use();
        return id_valid && ex_fwd_we && ex_fwd_is_load && (ex_fwd_rd != 5'd0) &&
               ((id_use_rs1 && ex_fwd_rd == id_rs1) || (id_use_rs2 && ex_fwd_rd == id_rs2));
    endfunction

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step();
        logic lu, exp_ready, acc;
        txn_t t;
        #2;
        lu        = ref_load_use();
        exp_ready = !lu && (!m_valid || ex_ready);
        chk("rf_rs1", 32'(rf_rs1), 32'(id_rs1));
        chk("rf_rs2", 32'(rf_rs2), 32'(id_rs2));
        if (!rst) chk("id_ready", 32'(id_ready), 32'(exp_ready));
        acc         = id_valid && exp_ready;
        t.pc        = id_pc;
        t.op_a      = ref_operand(id_rs1, rf_rd1);
        t.rs2_data  = ref_operand(id_rs2, rf_rd2);
        t.op_b      = id_use_imm ? id_imm : t.rs2_data;
        t.imm       = id_imm;
        t.rd        = id_rd;
        t.reg_write = id_reg_write;
        t.is_load   = id_is_load;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_slot  = '{default: '0};
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_slot  = t;
        end else if (ex_ready || !m_valid) begin
            m_valid = 1'b0;
        end
`ifdef OF_PERF_CNT_EN
        if (rst) begin
            m_lu_cnt = 0;
            m_fl_cnt = 0;
        end else begin
            m_lu_cnt += 32'(lu);
            m_fl_cnt += 32'(flush);
        end
`endif
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ex_pc", ex_pc, m_slot.pc);
        chk("ex_op_a", ex_op_a, m_slot.op_a);
        chk("ex_op_b", ex_op_b, m_slot.op_b);
        chk("ex_rs2_data", ex_rs2_data, m_slot.rs2_data);
        chk("ex_imm", ex_imm, m_slot.imm);
        chk("ex_rd", 32'(ex_rd), 32'(m_slot.rd));
        chk("ex_ctrl", {30'd0, ex_reg_write, ex_is_load}, {30'd0, m_slot.reg_write, m_slot.is_load});
`ifdef OF_PERF_CNT_EN
        chk("perf_lu_stalls", perf_lu_stalls, m_lu_cnt);
        chk("perf_flushes", perf_flushes, m_fl_cnt);
`endif
    endtask

    task automatic quiet_inputs();
        rst = 1'b0; flush = 1'b0; id_valid = 1'b0; id_pc = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_use_imm = 1'b0;
        id_reg_write = 1'b0; id_is_load = 1'b0;
        rf_rd1 = '0; rf_rd2 = '0;
        ex_fwd_we = 1'b0; ex_fwd_is_load = 1'b0; ex_fwd_rd = '0; ex_fwd_data = '0;
        mem_fwd_we = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        ex_ready = 1'b1;
    endtask

    task automatic random_inputs();
        rst            = ($urandom_range(0, 99) == 0);
        flush          = ($urandom_range(0, 19) == 0);
        id_valid       = ($urandom_range(0, 3) != 0);
        id_pc          = $urandom;
        id_imm         = $urandom;
        id_rs1         = 5'($urandom_range(0, 7));
        id_rs2         = 5'($urandom_range(0, 7));
        id_rd          = 5'($urandom);
        id_use_rs1     = 1'($urandom);
        id_use_rs2     = 1'($urandom);
        id_use_imm     = 1'($urandom);
        id_reg_write   = 1'($urandom);
        id_is_load     = 1'($urandom);
        rf_rd1         = $urandom;
        rf_rd2         = $urandom;
        ex_fwd_we      = 1'($urandom);
        ex_fwd_is_load = ($urandom_range(0, 2) == 0);
        ex_fwd_rd      = 5'($urandom_range(0, 7));
        ex_fwd_data    = $urandom;
        mem_fwd_we     = 1'($urandom);
        mem_fwd_rd     = 5'($urandom_range(0, 7));
        mem_fwd_data   = $urandom;
        wb_we          = 1'($urandom);
        wb_rd          = 5'($urandom_range(0, 7));
        wb_data        = $urandom;
        ex_ready       = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        logic [31:0] fl_before;
        m_valid = 1'b0;
        m_slot  = '{default: '0};
`ifdef OF_PERF_CNT_EN
        m_lu_cnt = 0;
        m_fl_cnt = 0;
`endif
        quiet_inputs();

        // Reset held for two cycles while decode offers an instruction.
        rst = 1'b1; id_valid = 1'b1; id_pc = 32'h40; id_rs1 = 5'd1; id_use_rs1 = 1'b1; rf_rd1 = 32'h99;
        step(); step();
        chk("reset_valid", 32'(ex_valid), 32'd0);
        chk("reset_op_a", ex_op_a, 32'd0);
        chk("reset_pc", ex_pc, 32'd0);

        // EX bypass.
        quiet_inputs();
        id_valid = 1'b1; id_rs1 = 5'd3; id_use_rs1 = 1'b1; rf_rd1 = 32'd5;
        ex_fwd_we = 1'b1; ex_fwd_rd = 5'd3; ex_fwd_data = 32'hAA;
        step();
        chk("ex_bypass", ex_op_a, 32'hAA);

        // Priority EX > MEM > WB, then x0.
        id_rs1 = 5'd4; rf_rd1 = 32'd9;
        ex_fwd_rd = 5'd4; ex_fwd_data = 32'd1;
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd4; mem_fwd_data = 32'd2;
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'd3;
        step(); chk("prio_ex", ex_op_a, 32'd1);
        ex_fwd_we = 1'b0;
        step(); chk("prio_mem", ex_op_a, 32'd2);
        mem_fwd_we = 1'b0;
        step(); chk("prio_wb", ex_op_a, 32'd3);
        ex_fwd_we = 1'b1; mem_fwd_we = 1'b1;
        id_rs1 = 5'd0; ex_fwd_rd = 5'd0; mem_fwd_rd = 5'd0; wb_rd = 5'd0;
        step(); chk("x0_zero", ex_op_a, 32'd0);

        // Load-use: one bubble, then the MEM bypass delivers the load data.
        quiet_inputs();
        id_valid = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1; id_pc = 32'h80; rf_rd2 = 32'h5;
        ex_fwd_we = 1'b1; ex_fwd_is_load = 1'b1; ex_fwd_rd = 5'd7;
        #1; chk("lu_ready", 32'(id_ready), 32'd0);
        step(); chk("lu_bubble", 32'(ex_valid), 32'd0);
        ex_fwd_we = 1'b0; ex_fwd_is_load = 1'b0;
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_data = 32'h1234;
        step();
        chk("lu_issue", 32'(ex_valid), 32'd1);
        chk("lu_mem_data", ex_rs2_data, 32'h1234);

        // Backpressure: held entry stays put for three cycles.
        quiet_inputs();
        id_valid = 1'b1; id_pc = 32'h100;
        step();
        ex_ready = 1'b0; id_pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_pc", ex_pc, 32'h100);
            chk("bp_ready", 32'(id_ready), 32'd0);
        end
        ex_ready = 1'b1;
        step();
        chk("bp_release_pc", ex_pc, 32'h200);

        // Flush beats a same-cycle accept.
`ifdef OF_PERF_CNT_EN
        fl_before = perf_flushes;
`else
        fl_before = 32'd0;
`endif
        flush = 1'b1; id_pc = 32'h300;
        step();
        chk("flush_valid", 32'(ex_valid), 32'd0);
`ifdef OF_PERF_CNT_EN
        chk("flush_count", perf_flushes, fl_before + 32'd1);
`endif
        flush = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            random_inputs();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
